// File: rtl/counter_pkg.sv
// Shared types for the up/down modulo counter and its bus interface.
package counter_pkg;

    // Counting mode selected on the mode input.
    typedef enum logic [1:0] {
        UP     = 2'd0,
        DOWN   = 2'd1,
        BOUNCE = 2'd2,
        HOLD   = 2'd3
    } cnt_mode_t;

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of updown_mod_counter: the master drives the controls,
// the counter (slave) returns count, direction and terminal-count pulse.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    import counter_pkg::*;

    logic             en;
    cnt_mode_t        mode;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             tc;

    modport master (
        output en, mode, limit, load, load_val,
        input  count, dir, tc
    );

    modport slave (
        input  en, mode, limit, load, load_val,
        output count, dir, tc
    );

endinterface

// File: rtl/tick_prescaler.sv
// Enable prescaler: raises tick on every PRESCALE-th enabled cycle. The phase
// counter holds while en_i is low and is cleared by clr_i. With PRESCALE=1
// tick is constantly high and no state exists.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // Clock, reset and controls are irrelevant without a divider.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, en_i, clr_i};
            assign tick_o        = 1'b1;
        end else begin : g_div
            localparam int              CW   = $clog2(PRESCALE);
            localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);
            localparam logic [CW-1:0]   ONE  = CW'(1);

            logic [CW-1:0] phase_q, phase_d;

            // Next phase: clear wins, otherwise advance (and wrap) on enabled cycles.
            always_comb begin
                // NOTE: default first so every path assigns phase_d; no latch is inferred.
                phase_d = phase_q;
                if (clr_i) begin
                    phase_d = '0;
                end else if (en_i) begin
                    phase_d = (phase_q == LAST) ? '0 : phase_q + ONE;
                end
            end

            // Phase register with asynchronous reset.
            always_ff @(posedge clk or posedge rst) begin
                // NOTE: non-blocking assignment for state so all flops update together.
                if (rst) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end

            assign tick_o = en_i && (phase_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo counter with run-time limit and UP / DOWN / BOUNCE / HOLD modes,
// synchronous clamped load, count enable with optional prescaler, and a
// registered one-cycle terminal-count pulse on every wrap or reversal.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_mod_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             tick;
    logic             step;
    logic [WIDTH-1:0] load_clamped;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (bus.en),
        .clr_i  (bus.load),
        .tick_o (tick)
    );

    assign step         = bus.en & tick;
    assign load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

    // Next count/direction/pulse: load beats step, step beats hold.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;

        if (bus.load) begin
            count_d = load_clamped;
        end else if (step && (bus.mode != HOLD)) begin
            if (bus.limit == '0) begin
                // Degenerate range: pinned at zero, every step is a wrap.
                count_d = '0;
                dir_d   = (bus.mode == DOWN);
                tc_d    = 1'b1;
            end else begin
                case (bus.mode)
                    UP: begin
                        dir_d = 1'b0;
                        if (count_q >= bus.limit) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end
                    DOWN: begin
                        dir_d = 1'b1;
                        if (count_q > bus.limit) begin
                            count_d = bus.limit;
                        end else if (count_q == '0) begin
                            count_d = bus.limit;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                    BOUNCE: begin
                        if (!dir_q) begin
                            // Rising leg: reverse at (or above) the top, skipping
                            // the top value so it appears once per period.
                            if (count_q >= bus.limit) begin
                                count_d = bus.limit - ONE;
                                dir_d   = 1'b1;
                                tc_d    = 1'b1;
                            end else begin
                                count_d = count_q + ONE;
                            end
                        end else begin
                            // Falling leg: a shrunk limit snaps back into range
                            // without a pulse; zero reverses upwards.
                            if (count_q > bus.limit) begin
                                count_d = bus.limit;
                            end else if (count_q == '0) begin
                                count_d = ONE;
                                dir_d   = 1'b0;
                                tc_d    = 1'b1;
                            end else begin
                                count_d = count_q - ONE;
                            end
                        end
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end
        end
    end

    // Single register stage for all outputs, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.tc    = tc_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: two counters (PRESCALE=1 and PRESCALE=3) share one set
// of controls and are compared each cycle against a behavioural model, plus
// directed sequences with hand-derived expected values.
module tb_updown_mod_counter;
    import counter_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en;
    cnt_mode_t    mode;
    logic [W-1:0] limit;
    logic         load;
    logic [W-1:0] load_val;

    int errors = 0;
    int checks = 0;

    // Model state per instance: index 0 -> PRESCALE=1, index 1 -> PRESCALE=3.
    int m_cnt [2];
    int m_dir [2];
    int m_tc  [2];
    int m_pre [2];

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(W)) bus1 ();
    updown_mod_counter_if #(.WIDTH(W)) bus3 ();

    assign bus1.en = en;       assign bus3.en = en;
    assign bus1.mode = mode;   assign bus3.mode = mode;
    assign bus1.limit = limit; assign bus3.limit = limit;
    assign bus1.load = load;   assign bus3.load = load;
    assign bus1.load_val = load_val;
    assign bus3.load_val = load_val;

    updown_mod_counter #(.WIDTH(W), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    updown_mod_counter #(.WIDTH(W), .PRESCALE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    function automatic int ps(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [5:0] got(int k);
        if (k == 0) return {bus1.count, bus1.dir, bus1.tc};
        return {bus3.count, bus3.dir, bus3.tc};
    endfunction

    function automatic logic [5:0] expv(int k);
        return {4'(m_cnt[k]), 1'(m_dir[k]), 1'(m_tc[k])};
    endfunction

    function automatic logic [5:0] pack(int c, int d, int t);
        return {4'(c), 1'(d), 1'(t)};
    endfunction

    function automatic void fail_msg(string tag, int k, logic [5:0] g, logic [5:0] e);
        $display("FAIL %s ps%0d: got count=%0d dir=%0d tc=%0d, want count=%0d dir=%0d tc=%0d",
                 tag, ps(k), g[5:2], g[1], g[0], e[5:2], e[1], e[0]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_dir[k] = 0; m_tc[k] = 0; m_pre[k] = 0;
        end
    endtask

    // One counting step from the mode rules, in plain integer arithmetic.
    task automatic model_count(int k, int lim);
        if (mode == HOLD) return;
        if (lim == 0) begin
            m_cnt[k] = 0; m_dir[k] = (mode == DOWN) ? 1 : 0; m_tc[k] = 1;
            return;
        end
        if (mode == UP) begin
            m_dir[k] = 0;
            if (m_cnt[k] >= lim) begin m_cnt[k] = 0; m_tc[k] = 1; end
            else m_cnt[k] = m_cnt[k] + 1;
        end else if (mode == DOWN) begin
            m_dir[k] = 1;
            if (m_cnt[k] > lim) m_cnt[k] = lim;
            else if (m_cnt[k] == 0) begin m_cnt[k] = lim; m_tc[k] = 1; end
            else m_cnt[k] = m_cnt[k] - 1;
        end else if (m_dir[k] == 0) begin
            if (m_cnt[k] >= lim) begin m_cnt[k] = lim - 1; m_dir[k] = 1; m_tc[k] = 1; end
            else m_cnt[k] = m_cnt[k] + 1;
        end else begin
            if (m_cnt[k] > lim) m_cnt[k] = lim;
            else if (m_cnt[k] == 0) begin m_cnt[k] = 1; m_dir[k] = 0; m_tc[k] = 1; end
            else m_cnt[k] = m_cnt[k] - 1;
        end
    endtask

    // Model effect of one rising edge, using the inputs present at the edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_tc[k] = 0;
            if (rst) begin
                m_cnt[k] = 0; m_dir[k] = 0; m_pre[k] = 0;
            end else if (load) begin
                m_cnt[k] = (int'(load_val) > int'(limit)) ? int'(limit) : int'(load_val);
                m_pre[k] = 0;
            end else if (en) begin
                m_pre[k] = m_pre[k] + 1;
                if (m_pre[k] == ps(k)) begin
                    m_pre[k] = 0;
                    model_count(k, int'(limit));
                end
            end
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        en = 1'b0; load = 1'b0;
        rst = 1'b1;
        model_reset();
        tick_clk();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b0; mode = UP; limit = '0; load = 1'b0; load_val = '0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got(k) !== 6'b0) begin errors++; fail_msg("reset_async", k, got(k), 6'b0); end
        end
        tick_clk();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got(k) !== expv(k)) begin errors++; fail_msg("reset_held", k, got(k), expv(k)); end
        end
    endtask

    // Triangle 0..14..0 with period 28 steps; pulses at 14->13 and 0->1.
    task automatic test_bounce14();
        apply_reset();
        mode = BOUNCE; limit = 4'd14; en = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            int p, c, d, t;
            tick_clk();
            p = s % 28;
            c = (p <= 14) ? p : 28 - p;
            d = (p > 14 || (p == 0 && s > 0)) ? 1 : 0;
            t = (p == 15 || (p == 1 && s > 28)) ? 1 : 0;
            checks++;
            if (got(0) !== pack(c, d, t)) begin errors++; fail_msg("bounce14_seq", 0, got(0), pack(c, d, t)); end
            checks++;
            if (got(1) !== expv(1)) begin errors++; fail_msg("bounce14_model", 1, got(1), expv(1)); end
        end
    endtask

    task automatic test_up9();
        apply_reset();
        mode = UP; limit = 4'd9; en = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            tick_clk();
            checks++;
            if (got(0) !== pack(s % 10, 0, (s % 10 == 0) ? 1 : 0)) begin
                errors++; fail_msg("up9_seq", 0, got(0), pack(s % 10, 0, (s % 10 == 0) ? 1 : 0));
            end
            checks++;
            if (got(1) !== expv(1)) begin errors++; fail_msg("up9_model", 1, got(1), expv(1)); end
        end
    endtask

    task automatic test_down_load();
        apply_reset();
        mode = DOWN; limit = 4'd7; load = 1'b1; load_val = 4'd12; en = 1'b1;
        tick_clk();
        load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got(k) !== pack(7, 0, 0)) begin errors++; fail_msg("down_load_clamp", k, got(k), pack(7, 0, 0)); end
        end
        for (int s = 1; s <= 9; s++) begin
            int c, t;
            tick_clk();
            c = (s <= 7) ? 7 - s : ((s == 8) ? 7 : 6);
            t = (s == 8) ? 1 : 0;
            checks++;
            if (got(0) !== pack(c, 1, t)) begin errors++; fail_msg("down_seq", 0, got(0), pack(c, 1, t)); end
            checks++;
            if (got(1) !== expv(1)) begin errors++; fail_msg("down_model", 1, got(1), expv(1)); end
        end
    endtask

    task automatic test_prescale();
        int pat  [7] = '{1, 1, 0, 1, 1, 1, 1};
        int cnt3 [7] = '{0, 0, 0, 1, 1, 1, 2};
        apply_reset();
        mode = UP; limit = 4'd15;
        for (int i = 0; i < 7; i++) begin
            en = pat[i][0];
            tick_clk();
            checks++;
            if (got(1) !== pack(cnt3[i], 0, 0)) begin errors++; fail_msg("prescale_seq", 1, got(1), pack(cnt3[i], 0, 0)); end
            checks++;
            if (got(0) !== expv(0)) begin errors++; fail_msg("prescale_model", 0, got(0), expv(0)); end
        end
    endtask

    task automatic test_limit_shrink();
        apply_reset();
        mode = BOUNCE; limit = 4'd14; load = 1'b1; load_val = 4'd10;
        tick_clk();
        load = 1'b0;
        checks++;
        if (got(0) !== pack(10, 0, 0)) begin errors++; fail_msg("shrink_load", 0, got(0), pack(10, 0, 0)); end
        limit = 4'd5; en = 1'b1;
        tick_clk();
        checks++;
        if (got(0) !== pack(4, 1, 1)) begin errors++; fail_msg("shrink_reverse", 0, got(0), pack(4, 1, 1)); end
        for (int s = 0; s < 6; s++) begin
            tick_clk();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== expv(k)) begin errors++; fail_msg("shrink_model", k, got(k), expv(k)); end
            end
        end
    endtask

    task automatic test_small_limits();
        cnt_mode_t modes [3] = '{UP, DOWN, BOUNCE};
        apply_reset();
        limit = '0; en = 1'b1;
        for (int m = 0; m < 3; m++) begin
            mode = modes[m];
            for (int s = 0; s < 3; s++) begin
                tick_clk();
                checks++;
                if (got(0) !== pack(0, (modes[m] == DOWN) ? 1 : 0, 1)) begin
                    errors++; fail_msg("limit0", 0, got(0), pack(0, (modes[m] == DOWN) ? 1 : 0, 1));
                end
                checks++;
                if (got(1) !== expv(1)) begin errors++; fail_msg("limit0_model", 1, got(1), expv(1)); end
            end
        end
        limit = 4'd1; mode = BOUNCE;
        for (int s = 1; s <= 8; s++) begin
            logic [5:0] g;
            tick_clk();
            g = got(0);
            checks++;
            if ({g[5:2], g[0]} !== {4'(s % 2), 1'(s >= 2)}) begin
                errors++; fail_msg("limit1_bounce", 0, g, pack(s % 2, 1 - (s % 2), (s >= 2) ? 1 : 0));
            end
            checks++;
            if (got(1) !== expv(1)) begin errors++; fail_msg("limit1_model", 1, got(1), expv(1)); end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        mode = UP; limit = 4'd9; load = 1'b1; load_val = 4'd5;
        tick_clk();
        load = 1'b0; mode = HOLD; en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick_clk();
            checks++;
            if (got(0) !== pack(5, 0, 0)) begin errors++; fail_msg("hold_frozen", 0, got(0), pack(5, 0, 0)); end
            checks++;
            if (got(1) !== expv(1)) begin errors++; fail_msg("hold_model", 1, got(1), expv(1)); end
        end
        mode = UP;
        for (int s = 0; s < 5; s++) begin
            tick_clk();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== expv(k)) begin errors++; fail_msg("hold_resume", k, got(k), expv(k)); end
            end
        end
    endtask

    task automatic test_rst_mid();
        apply_reset();
        mode = BOUNCE; limit = 4'd7; en = 1'b1;
        for (int s = 0; s < 8; s++) tick_clk();
        checks++;
        if (got(0) !== pack(6, 1, 1)) begin errors++; fail_msg("rst_mid_pre", 0, got(0), pack(6, 1, 1)); end
        #3 rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got(k) !== 6'b0) begin errors++; fail_msg("rst_mid_async", k, got(k), 6'b0); end
        end
        #1 rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick_clk();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== expv(k)) begin errors++; fail_msg("rst_mid_after", k, got(k), expv(k)); end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        mode = BOUNCE; limit = 4'd11;
        for (int i = 0; i < 600; i++) begin
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
            end
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = cnt_mode_t'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) limit = W'($urandom_range(0, 15));
            load = ($urandom_range(0, 11) == 0);
            load_val = W'($urandom_range(0, 15));
            tick_clk();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== expv(k)) begin errors++; fail_msg("random", k, got(k), expv(k)); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce14();
        test_up9();
        test_down_load();
        test_prescale();
        test_limit_shrink();
        test_small_limits();
        test_hold();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
